// File: rtl/fir_tap_loader.sv
// fir_tap_loader
//   Feeds filter coefficients from the host/config stream onto the FIR PE
//   chain's tap-load bus. Each accepted coefficient is tagged with a hop count.
//   Each PE latches the tap whose count reaches 0 at that PE, and forwards the
//   others with count-1. done pulses once the farthest tap is resident.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begins a load session (sampled only in IDLE)
//   abort        synchronous abort, back to IDLE from any state
//   num_taps     taps in the session (1..NUM_PE), latched on accepted start
//   reverse      0: k-th tap gets count k, 1: count num_taps-1-k
//   s_valid/s_ready/s_data   coefficient stream
//   tap_valid/tap_count/tap_data   tap-load bus into PE0 (all zero when idle)
//   busy         high in LOAD or DRAIN
//   done         one-cycle pulse, all taps resident
//   err          one-cycle pulse, start rejected for out-of-range num_taps
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting coefficients, one tap issued per accepted beat
// DRAIN | last tap issued, waiting for it to reach the farthest PE
module fir_tap_loader #(
    parameter int NUM_PE = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(NUM_PE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W:0]    num_taps,
    input  logic              reverse,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              tap_valid,
    output logic [CNT_W-1:0]  tap_count,
    output logic [DATA_W-1:0] tap_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W:0] MAX_TAPS = (CNT_W+1)'(NUM_PE);
    localparam logic [CNT_W:0] ONE      = (CNT_W+1)'(1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   idx_q;
    logic [CNT_W-1:0]   drain_q;
    logic [CNT_W:0]     n_q;
    logic               rev_q;

    logic               range_ok;
    logic               start_ok;
    logic               accept;
    logic               last_beat;
    logic               drain_end;
    logic [CNT_W-1:0]   count_sel;

    assign range_ok  = (num_taps != '0) && (num_taps <= MAX_TAPS);
    assign start_ok  = (state_q == IDLE) && start && range_ok && !abort;
    assign accept    = s_valid && s_ready;
    assign last_beat = ({1'b0, idx_q} == (n_q - ONE));
    assign drain_end = (state_q == DRAIN) && (drain_q == '0);
    assign count_sel = rev_q ? CNT_W'(n_q - ONE - {1'b0, idx_q}) : idx_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_ok) state_d = LOAD;
                LOAD:    if (accept && last_beat) state_d = DRAIN;
                DRAIN:   if (drain_q == '0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // state-decoded outputs
    always_comb begin
        s_ready = (state_q == LOAD) && !abort;
        busy    = (state_q == LOAD) || (state_q == DRAIN);
    end

    // session registers and the registered tap-load bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            drain_q   <= '0;
            n_q       <= '0;
            rev_q     <= 1'b0;
            tap_valid <= 1'b0;
            tap_count <= '0;
            tap_data  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            tap_valid <= accept;
            tap_count <= accept ? count_sel : '0;
            tap_data  <= accept ? s_data : '0;
            done      <= drain_end && !abort;
            err       <= (state_q == IDLE) && start && !range_ok && !abort;

            if (abort) begin
                idx_q   <= '0;
                drain_q <= '0;
            end else if (start_ok) begin
                n_q   <= num_taps;
                rev_q <= reverse;
                idx_q <= '0;
            end else if (accept) begin
                if (last_beat) begin
                    idx_q <= '0;
                    // Last tap is on the bus next cycle (T); this count
                    // reaches zero in T+num_taps-1 so done lands at T+num_taps.
                    drain_q <= CNT_W'(n_q - ONE);
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end else if ((state_q == DRAIN) && (drain_q != '0)) begin
                drain_q <= drain_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_loader.sv
// tb_fir_tap_loader
//   Directed bench for fir_tap_loader. A behavioural 16-PE chain model hangs
//   off the tap-load bus so resident taps can be compared after done.
//   Ports: none (top-level bench).
module tb_fir_tap_loader;

    localparam int NUM_PE = 16;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W:0]    num_taps = '0;
    logic              reverse = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              tap_valid;
    logic [CNT_W-1:0]  tap_count;
    logic [DATA_W-1:0] tap_data;
    logic              busy;
    logic              done;
    logic              err;

    fir_tap_loader #(.NUM_PE(NUM_PE), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .num_taps  (num_taps),
        .reverse   (reverse),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .tap_valid (tap_valid),
        .tap_count (tap_count),
        .tap_data  (tap_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // cycle counter and bus monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               q_cyc[$];
    logic [CNT_W-1:0] q_cnt[$];
    logic [31:0]      q_dat[$];
    int               n_done = 0;
    int               n_err = 0;
    int               done_cyc = 0;
    int               n_bus_bad = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tap_valid) begin
                q_cyc.push_back(cyc);
                q_cnt.push_back(tap_count);
                q_dat.push_back(tap_data);
            end else if (tap_count != '0 || tap_data != '0) begin
                n_bus_bad <= n_bus_bad + 1;
            end
            if (done) begin
                n_done   <= n_done + 1;
                done_cyc <= cyc;
            end
            if (err) n_err <= n_err + 1;
        end
    end

    // behavioural PE chain
    logic             in_v[NUM_PE];
    logic [CNT_W-1:0] in_c[NUM_PE];
    logic [31:0]      in_d[NUM_PE];
    logic             fw_v[NUM_PE] = '{default: 1'b0};
    logic [CNT_W-1:0] fw_c[NUM_PE] = '{default: '0};
    logic [31:0]      fw_d[NUM_PE] = '{default: '0};
    logic [31:0]      pe_q[NUM_PE] = '{default: '0};

    always_comb begin
        in_v[0] = tap_valid;
        in_c[0] = tap_count;
        in_d[0] = tap_data;
        for (int i = 1; i < NUM_PE; i++) begin
            in_v[i] = fw_v[i-1];
            in_c[i] = fw_c[i-1];
            in_d[i] = fw_d[i-1];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NUM_PE; i++) begin
            if (in_v[i] && in_c[i] == '0) pe_q[i] <= in_d[i];
            fw_v[i] <= in_v[i] && (in_c[i] != '0);
            fw_c[i] <= in_c[i] - 1'b1;
            fw_d[i] <= in_d[i];
        end
    end

    logic [31:0] exp_d[NUM_PE];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n, input bit rev);
        start    = 1'b1;
        num_taps = (CNT_W+1)'(n);
        reverse  = rev;
        tick();
        start    = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        s_valid = 1'b1;
        s_data  = d;
        #1 check("s_ready_load", s_ready, 1);
        tick();
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic wait_done(input int base);
        int k;
        k = 0;
        while (n_done == base && k < 60) begin
            tick();
            k++;
        end
        if (n_done == base) check("done_timeout", 0, 1);
    endtask

    // Compare logged taps from index base: expected count per k, data exp_d[k],
    // issue spacing `stride`, done at T+n, and resident PE contents.
    task automatic check_session(input int base, input int n, input bit rev, input int stride);
        int m, t_last, c;
        check("tap_total", q_cyc.size() - base, n);
        m = (q_cyc.size() - base < n) ? q_cyc.size() - base : n;
        for (int k = 0; k < m; k++) begin
            c = rev ? n - 1 - k : k;
            check("tap_count", q_cnt[base+k], c);
            check("tap_data", q_dat[base+k], exp_d[k]);
            check("tap_spacing", q_cyc[base+k] - q_cyc[base], stride * k);
        end
        if (m > 0) begin
            t_last = q_cyc[base+m-1];
            check("done_time", done_cyc - t_last, n);
        end
        for (int k = 0; k < n; k++) begin
            c = rev ? n - 1 - k : k;
            check("pe_resident", pe_q[c], exp_d[k]);
        end
        #1 check("busy_after_done", busy, 0);
    endtask

    initial begin
        int base, dbase, ebase;

        // reset state
        #3;
        check("rst_tap_valid", tap_valid, 0);
        check("rst_outputs", {busy, done, err, s_ready, tap_count, tap_data}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // forward load, back-to-back
        base = q_cyc.size();
        dbase = n_done;
        for (int k = 0; k < 4; k++) exp_d[k] = 32'hA000_0000 + k;
        do_start(4, 1'b0);
        check("busy_load", busy, 1);
        for (int k = 0; k < 4; k++) send_beat(exp_d[k]);
        wait_done(dbase);
        check_session(base, 4, 1'b0, 1);
        tick();

        // reverse load with s_valid gaps
        base = q_cyc.size();
        dbase = n_done;
        exp_d[0] = 32'h1111_1111;
        exp_d[1] = 32'h2222_2222;
        exp_d[2] = 32'h3333_3333;
        do_start(3, 1'b1);
        send_beat(exp_d[0]);
        tick();
        send_beat(exp_d[1]);
        tick();
        send_beat(exp_d[2]);
        wait_done(dbase);
        check_session(base, 3, 1'b1, 2);
        tick();

        // range check: 0 and NUM_PE+1 rejected
        ebase = n_err;
        do_start(0, 1'b0);
        check("err_zero", err, 1);
        check("busy_rej", busy, 0);
        check("s_ready_rej", s_ready, 0);
        tick();
        check("err_pulse_len", err, 0);
        do_start(17, 1'b0);
        check("err_over", err, 1);
        check("busy_rej2", {busy, s_ready}, 0);
        tick();
        check("err_count", n_err - ebase, 2);

        // full-length load
        base = q_cyc.size();
        dbase = n_done;
        for (int k = 0; k < 16; k++) exp_d[k] = 32'hC0DE_0000 + k * 3;
        do_start(16, 1'b0);
        for (int k = 0; k < 16; k++) send_beat(exp_d[k]);
        wait_done(dbase);
        check_session(base, 16, 1'b0, 1);
        tick();

        // abort mid-load, then a clean session
        base = q_cyc.size();
        dbase = n_done;
        do_start(8, 1'b0);
        for (int k = 0; k < 3; k++) send_beat(32'hDEAD_0000 + k);
        s_valid = 1'b1;
        s_data  = 32'hBAD0_BAD0;
        abort   = 1'b1;
        #1 check("s_ready_abort", s_ready, 0);
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        check("abort_idle", {busy, s_ready, tap_valid}, 0);
        for (int k = 0; k < 20; k++) tick();
        check("abort_no_done", n_done - dbase, 0);
        check("abort_taps", q_cyc.size() - base, 3);
        base = q_cyc.size();
        exp_d[0] = 32'h5555_0001;
        exp_d[1] = 32'h5555_0002;
        do_start(2, 1'b0);
        send_beat(exp_d[0]);
        send_beat(exp_d[1]);
        wait_done(dbase);
        check_session(base, 2, 1'b0, 1);
        tick();

        // start ignored while busy
        base = q_cyc.size();
        dbase = n_done;
        ebase = n_err;
        for (int k = 0; k < 3; k++) exp_d[k] = 32'h7700_0010 + k;
        do_start(3, 1'b0);
        send_beat(exp_d[0]);
        start = 1'b1;
        num_taps = '0;
        send_beat(exp_d[1]);
        start = 1'b0;
        send_beat(exp_d[2]);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(dbase);
        check_session(base, 3, 1'b0, 1);
        check("busy_start_no_err", n_err - ebase, 0);
        tick();

        // async reset in DRAIN
        dbase = n_done;
        do_start(4, 1'b0);
        for (int k = 0; k < 4; k++) send_beat(32'h9900_0000 + k);
        tick();
        check("drain_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_outputs", {busy, done, err, s_ready, tap_valid, tap_count, tap_data}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("rst_no_done", n_done - dbase, 0);
        check("rst_idle", busy, 0);

        check("bus_zero_when_idle", n_bus_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
